// File: rtl/skullfet_exerciser_pkg.sv
// Shared types and helpers for the skullfet cell exerciser.
// Holds the FSM state encoding, the stimulus vector width and the ideal cell functions.
package skullfet_exerciser_pkg;

   localparam int VEC_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2
   } state_e;

   function automatic logic exp_inv(input logic a);
      return ~a;
   endfunction

   function automatic logic exp_nand(input logic a, input logic b);
      return ~(a & b);
   endfunction

endpackage

// File: rtl/skullfet_exerciser_if.sv
// Control/status and cell stimulus/response bundle between firmware (la1), cells and exerciser.
// The master side is firmware plus cells; the slave side is the exerciser itself.
interface skullfet_exerciser_if #(
   parameter int SETTLE_W = 8,
   parameter int LOOP_W   = 8,
   parameter int ERR_W    = 16
);
   logic                start;
   logic                abort;
   logic [SETTLE_W-1:0] settle;
   logic [LOOP_W-1:0]   loops;
   logic                inv_y;
   logic                nand_y;
   logic                drv_a;
   logic                drv_b;
   logic                busy;
   logic                done;
   logic [ERR_W-1:0]    err_cnt;
   logic [1:0]          fail_mask;
   logic [1:0]          first_fail_vec;
   logic                first_fail_valid;

   modport master (
      output start, abort, settle, loops, inv_y, nand_y,
      input  drv_a, drv_b, busy, done, err_cnt, fail_mask, first_fail_vec, first_fail_valid
   );

   modport slave (
      input  start, abort, settle, loops, inv_y, nand_y,
      output drv_a, drv_b, busy, done, err_cnt, fail_mask, first_fail_vec, first_fail_valid
   );
endinterface

// File: rtl/skullfet_exerciser_exp_check.sv
// Combinational comparison of the cell outputs against the ideal response for the current vector.
// mismatch_o[0] flags the inverter, mismatch_o[1] flags the NAND.
module skullfet_exerciser_exp_check
   import skullfet_exerciser_pkg::*;
(
   input  logic [VEC_W-1:0] vec_i,
   input  logic             inv_y_i,
   input  logic             nand_y_i,
   output logic [1:0]       mismatch_o
);

   assign mismatch_o[0] = inv_y_i  ^ exp_inv(vec_i[0]);
   assign mismatch_o[1] = nand_y_i ^ exp_nand(vec_i[0], vec_i[1]);

endmodule

// File: rtl/skullfet_exerciser.sv
// Sweeps the skullfet inverter/NAND through all four {B,A} vectors, holds each for a
// programmable settle time, samples the cells and accumulates mismatch statistics.
module skullfet_exerciser
   import skullfet_exerciser_pkg::*;
#(
   parameter int SETTLE_W = 8,
   parameter int LOOP_W   = 8,
   parameter int ERR_W    = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   skullfet_exerciser_if.slave  bus
);

   state_e              state_q, state_d;
   logic [VEC_W-1:0]    vec_q, vec_d;
   logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [SETTLE_W-1:0] settle_eff_q, settle_eff_d;
   logic [LOOP_W-1:0]   loop_cnt_q, loop_cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
   logic [1:0]          fail_mask_q, fail_mask_d;
   logic [1:0]          ffv_q, ffv_d;
   logic                ffvalid_q, ffvalid_d;

   logic [1:0]          mismatch_s;
   logic [1:0]          mm_cnt_s;
   logic [ERR_W:0]      err_sum_s;
   logic [SETTLE_W-1:0] settle_in_s;

   skullfet_exerciser_exp_check u_exp_check (
      .vec_i      (vec_q),
      .inv_y_i    (bus.inv_y),
      .nand_y_i   (bus.nand_y),
      .mismatch_o (mismatch_s)
   );

   // A settle request of zero still holds each vector for one cycle.
   assign settle_in_s = (bus.settle == SETTLE_W'(0)) ? SETTLE_W'(1) : bus.settle;
   assign mm_cnt_s    = {1'b0, mismatch_s[0]} + {1'b0, mismatch_s[1]};
   assign err_sum_s   = {1'b0, err_cnt_q} + (ERR_W + 1)'(mm_cnt_s);

   // Next-state and datapath updates for the sweep FSM.
   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      settle_cnt_d = settle_cnt_q;
      settle_eff_d = settle_eff_q;
      loop_cnt_d   = loop_cnt_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_cnt_d    = err_cnt_q;
      fail_mask_d  = fail_mask_q;
      ffv_d        = ffv_q;
      ffvalid_d    = ffvalid_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (bus.start) begin
               err_cnt_d    = ERR_W'(0);
               fail_mask_d  = 2'b00;
               ffv_d        = 2'b00;
               ffvalid_d    = 1'b0;
               done_d       = 1'b0;
               vec_d        = 2'd0;
               settle_eff_d = settle_in_s;
               settle_cnt_d = settle_in_s - SETTLE_W'(1);
               loop_cnt_d   = bus.loops;
               busy_d       = 1'b1;
               state_d      = ST_SETTLE;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SETTLE: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               vec_d   = 2'd0;
            end else if (settle_cnt_q == SETTLE_W'(0)) begin
               state_d = ST_SAMPLE;
            end else begin
               settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
            end
         end

         ST_SAMPLE: begin
            // Statistics update first so an abort in this cycle still records the sample.
            fail_mask_d = fail_mask_q | mismatch_s;
            if (err_sum_s[ERR_W]) begin
               err_cnt_d = {ERR_W{1'b1}};
            end else begin
               err_cnt_d = err_sum_s[ERR_W-1:0];
            end
            if ((mismatch_s != 2'b00) && !ffvalid_q) begin
               ffv_d     = vec_q;
               ffvalid_d = 1'b1;
            end else begin
               ffv_d     = ffv_q;
               ffvalid_d = ffvalid_q;
            end

            if (bus.abort) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               vec_d   = 2'd0;
            end else if (vec_q != 2'd3) begin
               vec_d        = vec_q + 2'd1;
               settle_cnt_d = settle_eff_q - SETTLE_W'(1);
               state_d      = ST_SETTLE;
            end else if (loop_cnt_q == LOOP_W'(1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               vec_d   = 2'd0;
               state_d = ST_IDLE;
            end else begin
               vec_d        = 2'd0;
               settle_cnt_d = settle_eff_q - SETTLE_W'(1);
               if (loop_cnt_q != LOOP_W'(0)) begin
                  loop_cnt_d = loop_cnt_q - LOOP_W'(1);
               end else begin
                  loop_cnt_d = loop_cnt_q;
               end
               state_d = ST_SETTLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            vec_d   = 2'd0;
         end
      endcase
   end

   // State and status registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_IDLE;
         vec_q        <= 2'd0;
         settle_cnt_q <= SETTLE_W'(0);
         settle_eff_q <= SETTLE_W'(0);
         loop_cnt_q   <= LOOP_W'(0);
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_cnt_q    <= ERR_W'(0);
         fail_mask_q  <= 2'b00;
         ffv_q        <= 2'b00;
         ffvalid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         settle_cnt_q <= settle_cnt_d;
         settle_eff_q <= settle_eff_d;
         loop_cnt_q   <= loop_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_cnt_q    <= err_cnt_d;
         fail_mask_q  <= fail_mask_d;
         ffv_q        <= ffv_d;
         ffvalid_q    <= ffvalid_d;
      end
   end

   assign bus.drv_a            = vec_q[0];
   assign bus.drv_b            = vec_q[1];
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.err_cnt          = err_cnt_q;
   assign bus.fail_mask        = fail_mask_q;
   assign bus.first_fail_vec   = ffv_q;
   assign bus.first_fail_valid = ffvalid_q;

endmodule
